// File: rtl/fpu_seq_pkg.sv
// Shared opcode and FSM state encodings for the FP op sequencer.
package fpu_seq_pkg;

   localparam logic [5:0] OP_ADD_S  = 6'b100010;
   localparam logic [5:0] OP_SUB_S  = 6'b100011;
   localparam logic [5:0] OP_C_EQ_S = 6'b100100;
   localparam logic [5:0] OP_C_LE_S = 6'b100101;
   localparam logic [5:0] OP_C_LT_S = 6'b100110;
   localparam logic [5:0] OP_C_GE_S = 6'b100111;
   localparam logic [5:0] OP_C_GT_S = 6'b101000;
   localparam logic [5:0] OP_MOV_S  = 6'b101001;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_READ = 2'd1;
   localparam logic [1:0] ST_EXEC = 2'd2;
   localparam logic [1:0] ST_WB   = 2'd3;

endpackage

// File: rtl/fpu_op_class.sv
// Opcode classifier: which ops write fd, which update the condition flag.
module fpu_op_class
   import fpu_seq_pkg::*;
(
   input  logic [5:0] opcode,
   output logic       is_write,
   output logic       is_cmp,
   output logic       is_legal
);

   always_comb begin
      is_write = (opcode == OP_ADD_S) || (opcode == OP_SUB_S) || (opcode == OP_MOV_S);
      // The five compares occupy a contiguous opcode range.
      is_cmp   = (opcode >= OP_C_EQ_S) && (opcode <= OP_C_GT_S);
      is_legal = is_write || is_cmp;
   end

endmodule

// File: rtl/fpu_op_sequencer.sv
// IDLE->READ->EXEC->WB controller driving the shared combinational FPU.
// Optional FPU_SEQ_ILLEGAL_TRAP_EN adds an illegal_op flag instead of writing fd.
module fpu_op_sequencer
   import fpu_seq_pkg::*;
#(
   parameter int EXEC_CYCLES = 2,
   parameter int CNT_W       = 4
)(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [5:0]  req_opcode,
   input  logic [4:0]  req_fs,
   input  logic [4:0]  req_ft,
   input  logic [4:0]  req_fd,
   output logic [4:0]  rf_rd_addr1,
   output logic [4:0]  rf_rd_addr2,
   input  logic [31:0] rf_rd_data1,
   input  logic [31:0] rf_rd_data2,
   output logic [31:0] fpu_inp1,
   output logic [31:0] fpu_inp2,
   output logic [5:0]  fpu_opcode,
   input  logic [31:0] fpu_result,
   input  logic        fpu_cc,
   output logic        rf_wr_en,
   output logic [4:0]  rf_wr_addr,
   output logic [31:0] rf_wr_data,
   output logic        cc_flag,
   output logic        op_done,
`ifdef FPU_SEQ_ILLEGAL_TRAP_EN
   output logic        illegal_op,
`endif
   output logic        busy
);

   logic [1:0]       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [5:0]       opcode_q, opcode_d;
   logic [4:0]       fs_q, fs_d, ft_q, ft_d, fd_q, fd_d;
   logic [31:0]      op1_q, op1_d, op2_q, op2_d;
   logic [5:0]       fpu_op_q, fpu_op_d;
   logic [31:0]      res_q, res_d;
   logic             cc_res_q, cc_res_d;
   logic             cc_flag_q, cc_flag_d;
   logic             is_write, is_cmp, is_legal, write_class, in_wb;

   fpu_op_class u_class (
      .opcode   (opcode_q),
      .is_write (is_write),
      .is_cmp   (is_cmp),
      .is_legal (is_legal)
   );

`ifdef FPU_SEQ_ILLEGAL_TRAP_EN
   assign write_class = is_write;
   assign illegal_op  = in_wb && !is_legal;
`else
   // Unknown opcodes fall through as writes of whatever the FPU produced.
   assign write_class = is_write || !is_legal;
`endif

   always_comb begin
      // NOTE: every _d defaults to its _q so no path leaves a latch behind.
      state_d   = state_q;
      cnt_d     = cnt_q;
      opcode_d  = opcode_q;
      fs_d      = fs_q;
      ft_d      = ft_q;
      fd_d      = fd_q;
      op1_d     = op1_q;
      op2_d     = op2_q;
      fpu_op_d  = fpu_op_q;
      res_d     = res_q;
      cc_res_d  = cc_res_q;
      cc_flag_d = cc_flag_q;
      case (state_q)
         ST_IDLE: begin
            if (req_valid) begin
               opcode_d = req_opcode;
               fs_d     = req_fs;
               ft_d     = req_ft;
               fd_d     = req_fd;
               state_d  = ST_READ;
            end
         end
         ST_READ: begin
            // FPU-facing registers load together so they only move on this edge.
            op1_d    = rf_rd_data1;
            op2_d    = rf_rd_data2;
            fpu_op_d = opcode_q;
            cnt_d    = CNT_W'(EXEC_CYCLES - 1);
            state_d  = ST_EXEC;
         end
         ST_EXEC: begin
            if (cnt_q == '0) begin
               res_d    = fpu_result;
               cc_res_d = fpu_cc;
               state_d  = ST_WB;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         default: begin
            if (is_cmp) cc_flag_d = cc_res_q;
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      // NOTE: state uses non-blocking assignments; reset clears every register so an abandoned op leaves nothing behind.
      if (!rst_n) begin
         state_q   <= ST_IDLE;
         cnt_q     <= '0;
         opcode_q  <= '0;
         fs_q      <= '0;
         ft_q      <= '0;
         fd_q      <= '0;
         op1_q     <= '0;
         op2_q     <= '0;
         fpu_op_q  <= '0;
         res_q     <= '0;
         cc_res_q  <= 1'b0;
         cc_flag_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         opcode_q  <= opcode_d;
         fs_q      <= fs_d;
         ft_q      <= ft_d;
         fd_q      <= fd_d;
         op1_q     <= op1_d;
         op2_q     <= op2_d;
         fpu_op_q  <= fpu_op_d;
         res_q     <= res_d;
         cc_res_q  <= cc_res_d;
         cc_flag_q <= cc_flag_d;
      end
   end

   assign in_wb       = (state_q == ST_WB);
   assign req_ready   = rst_n && (state_q == ST_IDLE);
   assign busy        = (state_q != ST_IDLE);
   assign rf_rd_addr1 = fs_q;
   assign rf_rd_addr2 = ft_q;
   assign fpu_inp1    = op1_q;
   assign fpu_inp2    = op2_q;
   assign fpu_opcode  = fpu_op_q;
   assign op_done     = in_wb;
   assign rf_wr_en    = in_wb && write_class;
   assign rf_wr_addr  = fd_q;
   assign rf_wr_data  = res_q;
   assign cc_flag     = cc_flag_q;

endmodule

// File: tb/tb_fpu_op_sequencer.sv
// Randomized self-checking bench: FPU stub, FP register file and an op-level reference model.
module tb_fpu_op_sequencer;
   import fpu_seq_pkg::*;

   localparam int EC    = 2;
   localparam int CNT_W = 4;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic [5:0]  req_opcode = '0;
   logic [4:0]  req_fs = '0, req_ft = '0, req_fd = '0;
   logic [4:0]  rf_rd_addr1, rf_rd_addr2;
   logic [31:0] rf_rd_data1, rf_rd_data2;
   logic [31:0] fpu_inp1, fpu_inp2;
   logic [5:0]  fpu_opcode;
   logic [31:0] fpu_result;
   logic        fpu_cc;
   logic        rf_wr_en;
   logic [4:0]  rf_wr_addr;
   logic [31:0] rf_wr_data;
   logic        cc_flag, op_done, busy;
`ifdef FPU_SEQ_ILLEGAL_TRAP_EN
   logic        illegal_op;
   localparam bit TRAP = 1'b1;
`else
   localparam bit TRAP = 1'b0;
`endif

   fpu_op_sequencer #(.EXEC_CYCLES(EC), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
      .req_opcode(req_opcode), .req_fs(req_fs), .req_ft(req_ft), .req_fd(req_fd),
      .rf_rd_addr1(rf_rd_addr1), .rf_rd_addr2(rf_rd_addr2),
      .rf_rd_data1(rf_rd_data1), .rf_rd_data2(rf_rd_data2),
      .fpu_inp1(fpu_inp1), .fpu_inp2(fpu_inp2), .fpu_opcode(fpu_opcode),
      .fpu_result(fpu_result), .fpu_cc(fpu_cc),
      .rf_wr_en(rf_wr_en), .rf_wr_addr(rf_wr_addr), .rf_wr_data(rf_wr_data),
      .cc_flag(cc_flag), .op_done(op_done),
`ifdef FPU_SEQ_ILLEGAL_TRAP_EN
      .illegal_op(illegal_op),
`endif
      .busy(busy)
   );

   always #5 clk = ~clk;

   // Stand-in FPU: simple deterministic arithmetic, plus the one real FP sum used by the directed test.
   function automatic logic [31:0] fpu_res_f(input logic [31:0] a, input logic [31:0] b, input logic [5:0] op);
      case (op)
         OP_ADD_S: return (a == 32'h3F800000 && b == 32'h40000000) ? 32'h40400000 : a + b;
         OP_SUB_S: return a - b;
         OP_MOV_S: return a;
         default:  return 32'h0;
      endcase
   endfunction

   function automatic logic fpu_cc_f(input logic [31:0] a, input logic [31:0] b, input logic [5:0] op);
      case (op)
         OP_C_EQ_S: return a == b;
         OP_C_LE_S: return a <= b;
         OP_C_LT_S: return a < b;
         OP_C_GE_S: return a >= b;
         OP_C_GT_S: return a > b;
         default:   return 1'b0;
      endcase
   endfunction

   always_comb begin
      fpu_result = fpu_res_f(fpu_inp1, fpu_inp2, fpu_opcode);
      fpu_cc     = fpu_cc_f(fpu_inp1, fpu_inp2, fpu_opcode);
   end

   logic [31:0] rf_mem [32];
   logic [31:0] ref_rf [32];
   assign rf_rd_data1 = rf_mem[rf_rd_addr1];
   assign rf_rd_data2 = rf_mem[rf_rd_addr2];

   int wr_count = 0, done_count = 0, cycle = 0;
   always @(posedge clk) begin
      cycle <= cycle + 1;
      if (rst_n && rf_wr_en) begin
         rf_mem[rf_wr_addr] <= rf_wr_data;
         wr_count <= wr_count + 1;
      end
      if (rst_n && op_done) done_count <= done_count + 1;
   end

   int   errors = 0, checks = 0;
   int   exp_wr = 0, exp_done = 0, last_done = 0;
   logic cc_model = 1'b0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic set_reg(input int idx, input logic [31:0] v);
      rf_mem[idx] = v;
      ref_rf[idx] = v;
   endtask

   // Issue one op (called just after a negedge, returns just after the IDLE negedge that follows WB).
   task automatic run_op(input logic [5:0] op, input logic [4:0] fs, input logic [4:0] ft,
                         input logic [4:0] fd, input bit hold, input bit chk_gap);
      logic [31:0] a, b, exp_res;
      logic        exp_cc;
      bit          is_c, is_w, legal, wr;
      int          n;
      a       = ref_rf[fs];
      b       = ref_rf[ft];
      exp_res = fpu_res_f(a, b, op);
      exp_cc  = fpu_cc_f(a, b, op);
      is_c    = (op >= OP_C_EQ_S) && (op <= OP_C_GT_S);
      is_w    = (op == OP_ADD_S) || (op == OP_SUB_S) || (op == OP_MOV_S);
      legal   = is_c || is_w;
      wr      = is_w || (!legal && !TRAP);
      req_valid = 1'b1; req_opcode = op; req_fs = fs; req_ft = ft; req_fd = fd;
      n = 0;
      while (!req_ready && n < 20) begin @(negedge clk); n++; end
      check("accept_wait", 64'(n < 20), 1);
      if (n >= 20) begin req_valid = 1'b0; return; end
      @(posedge clk);
      n = 0;
      while (n < 40) begin
         @(negedge clk);
         n++;
         if (op_done) break;
         check("busy_ready", {req_ready, busy, rf_wr_en}, 3'b010);
      end
      check("latency", n, EC + 2);
      if (!op_done) begin req_valid = 1'b0; return; end
      check("no_early_write", wr_count, exp_wr);
      check("wb_ready_busy", {req_ready, busy}, 2'b01);
      check("wr_en", rf_wr_en, wr);
      if (wr) begin
         check("wr_addr", rf_wr_addr, fd);
         check("wr_data", rf_wr_data, exp_res);
      end
      check("fpu_operands", {fpu_inp1, fpu_inp2}, {a, b});
      check("fpu_opcode", fpu_opcode, op);
`ifdef FPU_SEQ_ILLEGAL_TRAP_EN
      check("illegal_op", illegal_op, !legal);
`endif
      if (wr) begin ref_rf[fd] = exp_res; exp_wr++; end
      if (is_c) cc_model = exp_cc;
      exp_done++;
      if (chk_gap) check("retire_gap", cycle - last_done, EC + 3);
      last_done = cycle;
      if (!hold) req_valid = 1'b0;
      @(negedge clk);
      check("cc_flag", cc_flag, cc_model);
      check("idle_ready_busy", {req_ready, busy, op_done, rf_wr_en}, 4'b1000);
      check("wr_count", wr_count, exp_wr);
      check("done_count", done_count, exp_done);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [5:0] ops [9];
      bit         hold;
      ops = '{OP_ADD_S, OP_SUB_S, OP_C_EQ_S, OP_C_LE_S, OP_C_LT_S,
              OP_C_GE_S, OP_C_GT_S, OP_MOV_S, 6'h3F};
      for (int i = 0; i < 32; i++) set_reg(i, $urandom);

      #2;
      check("rst_ctrl", {req_ready, busy, rf_wr_en, op_done, cc_flag}, 5'b0);
      check("rst_data", {fpu_inp1, fpu_inp2, rf_wr_data}, 96'b0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check("post_rst_ready", {req_ready, busy, cc_flag}, 3'b100);

      // 1.0 + 2.0 into f3.
      set_reg(1, 32'h3F800000);
      set_reg(2, 32'h40000000);
      run_op(OP_ADD_S, 5'd1, 5'd2, 5'd3, 1'b0, 1'b0);
      check("f3_value", rf_mem[3], 32'h40400000);

      // c.lt true then c.eq false.
      set_reg(4, 32'd1);
      set_reg(6, 32'd2);
      run_op(OP_C_LT_S, 5'd4, 5'd6, 5'd9, 1'b0, 1'b0);
      check("cc_after_lt", cc_flag, 1'b1);
      run_op(OP_C_EQ_S, 5'd4, 5'd6, 5'd9, 1'b0, 1'b0);
      check("cc_after_eq", cc_flag, 1'b0);

      // Three back-to-back ops with req_valid held.
      run_op(OP_SUB_S, 5'd7, 5'd8, 5'd10, 1'b1, 1'b0);
      run_op(OP_C_LT_S, 5'd4, 5'd6, 5'd11, 1'b1, 1'b1);
      run_op(OP_MOV_S, 5'd10, 5'd0, 5'd12, 1'b0, 1'b1);

      // Destination aliases a source.
      run_op(OP_ADD_S, 5'd5, 5'd6, 5'd5, 1'b0, 1'b0);
      check("f5_alias", rf_mem[5], ref_rf[5]);

      run_op(6'h3F, 5'd1, 5'd2, 5'd13, 1'b0, 1'b0);

      // Reset while in EXEC with cc_flag set.
      run_op(OP_C_LT_S, 5'd4, 5'd6, 5'd0, 1'b0, 1'b0);
      req_valid = 1'b1; req_opcode = OP_ADD_S; req_fs = 5'd1; req_ft = 5'd2; req_fd = 5'd14;
      @(posedge clk);
      req_valid = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("rst_exec_ctrl", {req_ready, busy, rf_wr_en, op_done, cc_flag}, 5'b0);
      check("rst_exec_fpu", {fpu_inp1, fpu_inp2, fpu_opcode}, 70'b0);
      check("rst_exec_wr", {rf_wr_addr, rf_wr_data, rf_rd_addr1, rf_rd_addr2}, 47'b0);
`ifdef FPU_SEQ_ILLEGAL_TRAP_EN
      check("rst_exec_illegal", illegal_op, 1'b0);
`endif
      cc_model = 1'b0;
      repeat (4) @(negedge clk);
      check("rst_no_write", wr_count, exp_wr);
      rst_n = 1'b1;
      @(negedge clk);
      check("rst_release", {req_ready, busy, cc_flag}, 3'b100);
      check("rst_no_done", done_count, exp_done);

      // Randomized ops.
      for (int k = 0; k < 40; k++) begin
         logic [4:0] fs, ft;
         fs   = 5'($urandom);
         ft   = ($urandom_range(0, 3) == 0) ? fs : 5'($urandom);
         hold = (k != 39) && ($urandom_range(0, 1) == 1);
         run_op(ops[$urandom_range(0, 8)], fs, ft, 5'($urandom), hold, 1'b0);
         if (!hold) repeat ($urandom_range(0, 2)) @(negedge clk);
      end
      for (int i = 0; i < 32; i++) check("rf_final", rf_mem[i], ref_rf[i]);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
